fifo_wr_arbiter: RTL

//  Round-robin write arbiter that shares one synchronous FIFO write port among
//  NUM_REQ producers. It grants one producer per cycle and muxes that producer's

---
 rtl/fifo_wr_arbiter_if.sv | 40 ++++
 rtl/fifo_wr_arbiter.sv | 113 +++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter_if
// Brief    : Producer/FIFO write-port bundle shared by the arbiter and its peers.
//            fifo_wdata width grows by ID_WIDTH when FIFO_ARB_TAG_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ID_WIDTH   = $clog2(NUM_REQ)
);
`ifdef FIFO_ARB_TAG_EN
    localparam int FW = DATA_WIDTH + ID_WIDTH;
`else
    localparam int FW = DATA_WIDTH;
`endif

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            gnt;
    logic                          fifo_full;
    logic                          fifo_wr_en;
    logic [FW-1:0]                 fifo_wdata;
    logic [ID_WIDTH-1:0]           owner;
    logic                          locked;

    // Arbiter side
    modport master (
        input  req, req_data, fifo_full,
        output gnt, fifo_wr_en, fifo_wdata, owner, locked
    );

    // Producers / FIFO side
    modport slave (
        output req, req_data, fifo_full,
        input  gnt, fifo_wr_en, fifo_wdata, owner, locked
    );
endinterface
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter
// Brief    : Round-robin, burst-locking arbiter for a single FIFO write port.
//            Define FIFO_ARB_TAG_EN to prefix each word with its source index.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4,
    parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  wire logic          clk,
    input  wire logic          rst,
    fifo_wr_arbiter_if.master  bus
);
    localparam int                  c_cnt_w   = $clog2(MAX_BURST + 1);
    localparam logic [c_cnt_w-1:0]  c_max_cnt = c_cnt_w'(MAX_BURST);
    localparam logic [c_cnt_w-1:0]  c_one_cnt = c_cnt_w'(1);
    localparam logic [ID_WIDTH-1:0] c_last_id = ID_WIDTH'(NUM_REQ - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ID_WIDTH-1:0] rr_last_q, rr_last_d;
    logic [ID_WIDTH-1:0] owner_q, owner_d;
    logic [c_cnt_w-1:0]  cnt_q, cnt_d;

    logic [NUM_REQ-1:0]    w_gnt;
    logic [ID_WIDTH-1:0]   w_sel;
    logic [ID_WIDTH-1:0]   w_pick;
    logic [ID_WIDTH-1:0]   w_idx;
    logic                  w_found;
    logic [DATA_WIDTH-1:0] w_word;

    always_comb begin
        state_d   = state_q;
        rr_last_d = rr_last_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        w_gnt     = '0;
        w_sel     = owner_q;
        w_pick    = rr_last_q;
        w_idx     = '0;
        w_found   = 1'b0;

        // First requester strictly after the last winner, wrapping around
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = ID_WIDTH'((int'(rr_last_q) + 1 + k) % NUM_REQ);
            if (!w_found && bus.req[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end

        if (!rst) begin
            case (state_q)
                ST_IDLE: begin
                    if (w_found && !bus.fifo_full) begin
                        w_gnt[w_pick] = 1'b1;
                        w_sel         = w_pick;
                        owner_d       = w_pick;
                        rr_last_d     = w_pick;
                        cnt_d         = c_one_cnt;
                        state_d       = (MAX_BURST > 1) ? ST_LOCK : ST_IDLE;
                    end
                end
                ST_LOCK: begin
                    // Burst end or owner withdrawal costs one bubble cycle
                    if (!bus.req[owner_q] || (cnt_q == c_max_cnt)) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (!bus.fifo_full) begin
                        w_gnt[owner_q] = 1'b1;
                        cnt_d          = cnt_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rr_last_q <= c_last_id;
            owner_q   <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
        end
    end

    assign w_word = (|w_gnt) ? bus.req_data[int'(w_sel)*DATA_WIDTH +: DATA_WIDTH] : '0;

    assign bus.gnt        = w_gnt;
    assign bus.fifo_wr_en = |w_gnt;
`ifdef FIFO_ARB_TAG_EN
    assign bus.fifo_wdata = (|w_gnt) ? {w_sel, w_word} : '0;
`else
    assign bus.fifo_wdata = w_word;
`endif
    assign bus.owner      = owner_q;
    assign bus.locked     = (state_q == ST_LOCK);
endmodule
`default_nettype wire
